// File: rtl/threedeeohpad_chain.sv
// threedeeohpad_chain
//   3DO controller-port serialiser. It emulates NUM_PADS daisy-chained pads on
//   one console port. While ps is high, every pad word is latched. Once ps is
//   low, the words are shifted out MSB-first, pad 0 first, one bit per rising
//   edge of the console clk. The console pins are resynchronised, and all state
//   runs on system_clock.
//
//   Optional feature: define DAISY_CHAIN_EN to add the chain_in port. When the
//   local pads are exhausted, chain_in (downstream pad data) is passed through
//   to dat. Without the macro, dat idles high after the last local bit.
//
// Ports
//   system_clock    in   system clock, rising edge
//   system_reset_n  in   async active-low reset
//   ps              in   console parallel/serial select (high = latch)
//   clk             in   console shift clock
//   dat             out  serial data to console (active-low buttons, idle high)
//   i               in   pad words, pad k = i[k*BITS +: BITS], 1 = pressed
//   chain_in        in   downstream pad data (DAISY_CHAIN_EN only)
//   bit_count       out  bits shifted this frame, saturates at TOTAL
//   frame_done      out  one-cycle pulse when bit_count reaches TOTAL
module threedeeohpad_chain #(
    parameter  int BITS        = 16,
    parameter  int NUM_PADS    = 2,
    parameter  int SYNC_STAGES = 2,
    localparam int TOTAL       = NUM_PADS * BITS,
    localparam int CW          = $clog2(TOTAL + 1)
) (
    input  logic             system_clock,
    input  logic             system_reset_n,
    input  logic             ps,
    input  logic             clk,
    output logic             dat,
    input  logic [TOTAL-1:0] i,
`ifdef DAISY_CHAIN_EN
    input  logic             chain_in,
`endif
    output logic [CW-1:0]    bit_count,
    output logic             frame_done
);

    // Pad 0 occupies the top of the shift register, so it leaves first.
    logic [TOTAL-1:0] load_word;
    for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
        assign load_word[TOTAL-1-k*BITS -: BITS] = i[k*BITS +: BITS];
    end

    logic [SYNC_STAGES-1:0] ps_sync, clk_sync;
    logic                   clk_s_d;
    logic [TOTAL-1:0]       sr;
    logic                   ps_s, clk_s, clk_rise, at_end, dat_next;

    assign ps_s     = ps_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_s_d;
    assign at_end   = (bit_count == CW'(TOTAL));

`ifdef DAISY_CHAIN_EN
    logic [SYNC_STAGES-1:0] chain_sync;
    logic                   chain_s;
    assign chain_s = chain_sync[SYNC_STAGES-1];

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) chain_sync <= '0;
        else                 chain_sync <= {chain_sync[SYNC_STAGES-2:0], chain_in};
    end
`endif

    // Value dat should take on the next console low-phase cycle.
    always_comb begin
        dat_next = 1'b1;
        if (!ps_s) begin
            if (!at_end) begin
                dat_next = ~sr[TOTAL-1];
            end else begin
`ifdef DAISY_CHAIN_EN
                dat_next = chain_s;
`else
                dat_next = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            ps_sync    <= '0;
            clk_sync   <= '0;
            clk_s_d    <= 1'b0;
            sr         <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
            dat        <= 1'b1;
        end else begin
            ps_sync    <= {ps_sync[SYNC_STAGES-2:0], ps};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], clk};
            clk_s_d    <= clk_s;
            frame_done <= 1'b0;
            // Latch wins over a coincident clk edge.
            if (ps_s) begin
                sr        <= load_word;
                bit_count <= '0;
            end else if (clk_rise) begin
                sr <= {sr[TOTAL-2:0], 1'b0};
                // Saturate at TOTAL, so the pulse fires only once per frame.
                if (!at_end) begin
                    bit_count <= bit_count + 1'b1;
                    if (bit_count == CW'(TOTAL - 1)) frame_done <= 1'b1;
                end
            end
            // dat only changes while the console clock is low.
            if (!clk_s) dat <= dat_next;
        end
    end

endmodule

// File: tb/tb_threedeeohpad_chain.sv
module tb_threedeeohpad_chain;

    localparam int BITS = 16, NUM_PADS = 2, SYNC = 2;
    localparam int TOTAL = BITS * NUM_PADS;
    localparam int HALF = 8;   // console half-period in system_clock cycles

    logic system_clock = 1'b0, system_reset_n = 1'b0;
    logic ps = 1'b0, clk = 1'b0, dat, frame_done;
    logic [TOTAL-1:0] i = '0;
    logic [5:0] bit_count;
`ifdef DAISY_CHAIN_EN
    logic chain_in = 1'b1;
`endif

    threedeeohpad_chain #(.BITS(BITS), .NUM_PADS(NUM_PADS), .SYNC_STAGES(SYNC)) dut (
        .system_clock(system_clock), .system_reset_n(system_reset_n),
        .ps(ps), .clk(clk), .dat(dat), .i(i),
`ifdef DAISY_CHAIN_EN
        .chain_in(chain_in),
`endif
        .bit_count(bit_count), .frame_done(frame_done));

    always #5 system_clock = ~system_clock;

    int n_chk = 0, n_pass = 0, fd_cnt = 0;
    logic exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: the console samples dat on its clk rise.
    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            chk("dat_bit", {31'b0, dat}, {31'b0, e});
        end
    end

    always @(negedge system_clock) if (system_reset_n && frame_done) fd_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic cyc(int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic clk_bit(logic e);
        exp_q.push_back(e);
        clk = 1'b1; cyc(HALF);
        clk = 1'b0; cyc(HALF);
    endtask

    task automatic latch(logic [TOTAL-1:0] w);
        i = w; ps = 1'b1; cyc(6); ps = 1'b0; cyc(6);
    endtask

    // Expected dat for serial bit n: inverted pad bit, pad 0 first, MSB first.
    function automatic logic exp_bit(logic [TOTAL-1:0] w, int n);
        logic [BITS-1:0] pw;
        pw = w[(n / BITS) * BITS +: BITS];
        return ~pw[BITS-1 - (n % BITS)];
    endfunction

    initial begin
        logic [TOTAL-1:0] w;
        int fd0;

        // 1: reset with pins toggling.
        repeat (4) begin ps = ~ps; clk = ~clk; cyc(2); end
        chk("rst_dat", {31'b0, dat}, 32'd1);
        chk("rst_count", {26'b0, bit_count}, 32'd0);
        chk("rst_fd", {31'b0, frame_done}, 32'd0);
        ps = 1'b0; clk = 1'b0; cyc(4);
        system_reset_n = 1'b1; cyc(4);

        // 2: known pattern, one full frame.
        w = {16'h0000, 16'h8001};
        latch(w);
        chk("first_dat", {31'b0, dat}, 32'd0);
        clk_bit(1'b0);
        repeat (14) clk_bit(1'b1);
        clk_bit(1'b0);
        repeat (16) clk_bit(1'b1);
        cyc(4);
        chk("count_full", {26'b0, bit_count}, 32'd32);
        chk("fd_once", fd_cnt, 32'd1);

        // 3: overflow saturates, dat stays high.
        repeat (8) clk_bit(1'b1);
        chk("count_sat", {26'b0, bit_count}, 32'd32);
        chk("fd_no_repeat", fd_cnt, 32'd1);

`ifdef DAISY_CHAIN_EN
        // 4: downstream data passes through after the local bits.
        chain_in = 1'b0; cyc(SYNC + 1);
        chk("chain_pass", {31'b0, dat}, 32'd0);
        chain_in = 1'b1; cyc(SYNC + 2);
        chk("chain_pass_hi", {31'b0, dat}, 32'd1);
`endif

        // 5: ps reasserted mid-frame.
        w = {16'h1234, 16'hA5C3};
        latch(w);
        for (int n = 0; n < 10; n++) clk_bit(exp_bit(w, n));
        ps = 1'b1; cyc(6);
        chk("abort_count", {26'b0, bit_count}, 32'd0);
        chk("abort_dat", {31'b0, dat}, 32'd1);
        chk("abort_no_fd", fd_cnt, 32'd1);
        ps = 1'b0; cyc(6);
        // Restart at pad 0 MSB; a mid-frame change of i must not matter.
        for (int n = 0; n < TOTAL; n++) begin
            if (n == 5) i = 32'hFFFF_0000;
            clk_bit(exp_bit(w, n));
        end
        cyc(4);
        chk("restart_fd", fd_cnt, 32'd2);

        // 6: clk rise coincident with ps high, latch wins.
        w = {16'h00FF, 16'h7E01};
        latch(w);
        for (int n = 0; n < 3; n++) clk_bit(exp_bit(w, n));
        chk("pre_coinc_count", {26'b0, bit_count}, 32'd3);
        ps = 1'b1; clk = 1'b1; cyc(HALF);
        chk("coinc_count", {26'b0, bit_count}, 32'd0);
        clk = 1'b0; cyc(4); ps = 1'b0; cyc(6);
        fd0 = fd_cnt;
        for (int n = 0; n < TOTAL; n++) clk_bit(exp_bit(w, n));
        cyc(4);
        chk("coinc_fd", fd_cnt - fd0, 32'd1);

        // Reset mid-frame.
        latch({16'hFFFF, 16'hFFFF});
        for (int n = 0; n < 4; n++) clk_bit(1'b0);
        system_reset_n = 1'b0; cyc(2);
        chk("midrst_count", {26'b0, bit_count}, 32'd0);
        chk("midrst_dat", {31'b0, dat}, 32'd1);
        chk("midrst_fd", {31'b0, frame_done}, 32'd0);
        system_reset_n = 1'b1; cyc(4);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
